// File: rtl/ddr3_write_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one Avalon-MM DDR3 write port among NUM_REQ
// burst writers; a grant lasts for exactly one burst, then re-arbitrates.
//
// Ports:
//   ddr3_clk, ddr3clk_reset        clock, synchronous active-high reset
//   req_address/_write_data/_write/_burstcount   flattened per-requester
//                                  master inputs (requester i at slice i)
//   req_waitrequest                per-requester stall
//   ddr3_write_address/_data/_write/_burstcount  master side to controller
//   ddr3_waitrequest               stall from controller
//   grant_valid, grant_index       registered owner of the port
module ddr3_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 256
) (
    input  logic                      ddr3_clk,
    input  logic                      ddr3clk_reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*2-1:0]      req_burstcount,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [ADDR_W-1:0]         ddr3_write_address,
    output logic [DATA_W-1:0]         ddr3_write_data,
    output logic                      ddr3_write,
    output logic [1:0]                ddr3_burstcount,
    input  logic                      ddr3_waitrequest,
    output logic                      grant_valid,
    output logic [1:0]                grant_index
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] g_q, g_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] beat_q, beat_d;
    logic [1:0] blen_q, blen_d;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_bc;
    logic              sel_wr;
    logic [1:0]        bc_eff;
    logic              accept;
    logic              last;
    logic              pick_vld;
    logic [1:0]        pick;

    // (base + off) mod NUM_REQ, with base < NUM_REQ and off <= NUM_REQ
    function automatic logic [1:0] rr_idx(input logic [1:0] base,
                                          input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[1:0];
    endfunction

    // Owner mux; requester 0 is driven while idle
    always_comb begin
        sel_addr = req_address[ADDR_W-1:0];
        sel_data = req_write_data[DATA_W-1:0];
        sel_bc   = req_burstcount[1:0];
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == ST_GRANT && g_q == 2'(i)) begin
                sel_addr = req_address[i*ADDR_W +: ADDR_W];
                sel_data = req_write_data[i*DATA_W +: DATA_W];
                sel_bc   = req_burstcount[i*2 +: 2];
                sel_wr   = req_write[i];
            end
        end
    end

    always_comb begin
        req_waitrequest = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state_q == ST_GRANT && g_q == 2'(i))
                req_waitrequest[i] = ddr3_waitrequest;
        end
    end

    assign ddr3_write_address = sel_addr;
    assign ddr3_write_data    = sel_data;
    assign ddr3_burstcount    = sel_bc;
    assign ddr3_write         = sel_wr;
    assign grant_valid        = (state_q == ST_GRANT);
    assign grant_index        = g_q;

    assign bc_eff = (sel_bc == 2'd0) ? 2'd1 : sel_bc;
    assign accept = ddr3_write && !ddr3_waitrequest;
    // First beat uses the live burstcount; later beats the latched length
    assign last   = accept && ((beat_q == 2'd0) ? (bc_eff == 2'd1)
                                                : (beat_q == blen_q - 2'd1));

    // Scan from rr_q; walking offsets downward lets the nearest one win
    always_comb begin
        pick_vld = 1'b0;
        pick     = 2'd0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_write[j] && 2'(j) == rr_idx(rr_q, o)) begin
                    pick_vld = 1'b1;
                    pick     = 2'(j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        blen_d  = blen_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    g_d     = pick;
                    beat_d  = 2'd0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    if (beat_q == 2'd0) blen_d = bc_eff;
                    if (last) begin
                        state_d = ST_IDLE;
                        beat_d  = 2'd0;
                        rr_d    = rr_idx(g_q, 1);
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else if (beat_q == 2'd0 && !sel_wr) begin
                    // Owner withdrew before any beat: no turn consumed
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr3_clk) begin
        if (ddr3clk_reset) begin
            state_q <= ST_IDLE;
            g_q     <= 2'd0;
            rr_q    <= 2'd0;
            beat_q  <= 2'd0;
            blen_q  <= 2'd1;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            blen_q  <= blen_d;
        end
    end

endmodule

// File: tb/tb_ddr3_write_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for ddr3_write_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ddr3_write_arbiter;

    localparam int NR = 2;
    localparam int AW = 27;
    localparam int DW = 256;

    logic            clk;
    logic            rst;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rwr;
    logic [NR*2-1:0]  rbc;
    logic [NR-1:0]    rwait;
    logic [AW-1:0]    daddr;
    logic [DW-1:0]    ddata;
    logic             dwr;
    logic [1:0]       dbc;
    logic             dwait;
    logic             gv;
    logic [1:0]       gi;

    int n_chk;
    int n_pass;
    logic [299:0] got;
    logic [299:0] exp;

    ddr3_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ddr3_clk           (clk),
        .ddr3clk_reset      (rst),
        .req_address        (raddr),
        .req_write_data     (rdata),
        .req_write          (rwr),
        .req_burstcount     (rbc),
        .req_waitrequest    (rwait),
        .ddr3_write_address (daddr),
        .ddr3_write_data    (ddata),
        .ddr3_write         (dwr),
        .ddr3_burstcount    (dbc),
        .ddr3_waitrequest   (dwait),
        .grant_valid        (gv),
        .grant_index        (gi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkd(input logic [31:0] x);
        return {8{x}};
    endfunction

    // {ddr3_write, grant_valid, req_waitrequest[1:0]}
    function automatic logic [3:0] st();
        return {dwr, gv, rwait};
    endfunction

    task automatic set_req(input int i, input logic w,
                           input logic [AW-1:0] a, input logic [1:0] b,
                           input logic [DW-1:0] d);
        rwr[i]         = w;
        raddr[i*AW+:AW] = a;
        rbc[i*2+:2]    = b;
        rdata[i*DW+:DW] = d;
    endtask

    task automatic idle_all();
        rwr   = '0;
        raddr = '0;
        rdata = '0;
        rbc   = '0;
        dwait = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 27'h55, 2'd2, mkd(32'h0000_00A5));
        set_req(1, 1'b1, 27'h66, 2'd2, mkd(32'h0000_00B6));
        dwait = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            got = {st(), gi}; exp = {4'b0011, 2'd0};
            n_chk++;
            if (got !== exp) $display("FAIL reset_c%0d: got %h want %h", c, got, exp);
            else n_pass++;
        end
        got = {daddr, dbc, ddata};
        exp = {27'h55, 2'd2, mkd(32'h0000_00A5)};
        n_chk++;
        if (got !== exp) $display("FAIL reset_idle_mux: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        idle_all();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'h0000100, 2'd2, mkd(32'hAAAA_0001));
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL single_c0: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, daddr, dbc, ddata};
        exp = {4'b1110, 2'd0, 27'h0000100, 2'd2, mkd(32'hAAAA_0001)};
        n_chk++;
        if (got !== exp) $display("FAIL single_c1: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        set_req(0, 1'b1, 27'h0000100, 2'd2, mkd(32'hBBBB_0002));
        #1;
        got = {st(), gi, daddr, dbc, ddata};
        exp = {4'b1110, 2'd0, 27'h0000100, 2'd2, mkd(32'hBBBB_0002)};
        n_chk++;
        if (got !== exp) $display("FAIL single_c2: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rwr[0] = 1'b0;
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL single_c3: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'h200, 2'd2, mkd(32'hA000_0000));
        set_req(1, 1'b1, 27'h300, 2'd2, mkd(32'hB000_0000));
        @(negedge clk); #1;
        got = {st(), gi, daddr, ddata};
        exp = {4'b1110, 2'd0, 27'h200, mkd(32'hA000_0000)};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c1: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rdata[0*DW+:DW] = mkd(32'hA000_0001);
        #1;
        got = {st(), gi, ddata};
        exp = {4'b1110, 2'd0, mkd(32'hA000_0001)};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c2: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rdata[0*DW+:DW] = mkd(32'hA000_0002);
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL sim_bubble: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, daddr, ddata};
        exp = {4'b1101, 2'd1, 27'h300, mkd(32'hB000_0000)};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c4: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rdata[1*DW+:DW] = mkd(32'hB000_0001);
        #1;
        got = {st(), gi, ddata};
        exp = {4'b1101, 2'd1, mkd(32'hB000_0001)};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c5: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rwr[1] = 1'b0;
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c6: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, ddata};
        exp = {4'b1110, 2'd0, mkd(32'hA000_0002)};
        n_chk++;
        if (got !== exp) $display("FAIL sim_c7: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_stall();
        int beats;
        beats = 0;
        do_reset();
        @(negedge clk);
        set_req(1, 1'b1, 27'h400, 2'd2, mkd(32'hB100_0000));
        @(negedge clk);
        set_req(0, 1'b1, 27'h500, 2'd1, mkd(32'hA100_0000));
        #1;
        if (dwr && !dwait && gi == 2'd1) beats++;
        got = {st(), gi, ddata};
        exp = {4'b1101, 2'd1, mkd(32'hB100_0000)};
        n_chk++;
        if (got !== exp) $display("FAIL stall_c1: got %h want %h", got, exp);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rdata[1*DW+:DW] = mkd(32'hB100_0001);
            dwait = 1'b1;
            #1;
            if (dwr && !dwait && gi == 2'd1) beats++;
            got = {st(), gi}; exp = {4'b1111, 2'd1};
            n_chk++;
            if (got !== exp) $display("FAIL stall_w%0d: got %h want %h", c, got, exp);
            else n_pass++;
        end
        @(negedge clk);
        dwait = 1'b0;
        #1;
        if (dwr && !dwait && gi == 2'd1) beats++;
        got = {st(), gi, ddata};
        exp = {4'b1101, 2'd1, mkd(32'hB100_0001)};
        n_chk++;
        if (got !== exp) $display("FAIL stall_c5: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rwr[1] = 1'b0;
        #1;
        if (dwr && !dwait && gi == 2'd1 && gv) beats++;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL stall_c6: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, daddr}; exp = {4'b1110, 2'd0, 27'h500};
        n_chk++;
        if (got !== exp) $display("FAIL stall_c7: got %h want %h", got, exp);
        else n_pass++;
        n_chk++;
        if (beats !== 2) $display("FAIL stall_beats: got %0d want 2", beats);
        else n_pass++;
    endtask

    task automatic test_mixed();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'h600, 2'd1, mkd(32'hA200_0000));
        set_req(1, 1'b1, 27'h700, 2'd2, mkd(32'hB200_0000));
        @(negedge clk); #1;
        got = {st(), gi, dbc}; exp = {4'b1110, 2'd0, 2'd1};
        n_chk++;
        if (got !== exp) $display("FAIL mixed_c1: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL mixed_c2: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, daddr}; exp = {4'b1101, 2'd1, 27'h700};
        n_chk++;
        if (got !== exp) $display("FAIL mixed_c3: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_bc_zero();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'h650, 2'd0, mkd(32'hA300_0000));
        @(negedge clk); #1;
        got = {st(), gi}; exp = {4'b1110, 2'd0};
        n_chk++;
        if (got !== exp) $display("FAIL bc0_c1: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL bc0_c2: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_gap();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'h800, 2'd2, mkd(32'hA400_0000));
        set_req(1, 1'b1, 27'h900, 2'd2, mkd(32'hB400_0000));
        @(negedge clk); #1;
        got = {st(), gi, ddata};
        exp = {4'b1110, 2'd0, mkd(32'hA400_0000)};
        n_chk++;
        if (got !== exp) $display("FAIL gap_c1: got %h want %h", got, exp);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rwr[0] = 1'b0;
            #1;
            got = {st(), gi}; exp = {4'b0110, 2'd0};
            n_chk++;
            if (got !== exp) $display("FAIL gap_hold%0d: got %h want %h", c, got, exp);
            else n_pass++;
        end
        @(negedge clk);
        set_req(0, 1'b1, 27'h800, 2'd2, mkd(32'hA400_0001));
        #1;
        got = {st(), gi, ddata};
        exp = {4'b1110, 2'd0, mkd(32'hA400_0001)};
        n_chk++;
        if (got !== exp) $display("FAIL gap_c4: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rwr[0] = 1'b0;
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL gap_c5: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi}; exp = {4'b1101, 2'd1};
        n_chk++;
        if (got !== exp) $display("FAIL gap_c6: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 27'hA00, 2'd1, mkd(32'hA500_0000));
        @(negedge clk); #1;
        got = {st(), gi}; exp = {4'b1110, 2'd0};
        n_chk++;
        if (got !== exp) $display("FAIL rmid_c1: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        rwr[0] = 1'b0;
        set_req(1, 1'b1, 27'hB00, 2'd2, mkd(32'hB500_0000));
        @(negedge clk); #1;
        got = {st(), gi}; exp = {4'b1101, 2'd1};
        n_chk++;
        if (got !== exp) $display("FAIL rmid_c3: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk);
        set_req(0, 1'b1, 27'hA10, 2'd2, mkd(32'hA500_0001));
        rdata[1*DW+:DW] = mkd(32'hB500_0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        got = {st()}; exp = {4'b0011};
        n_chk++;
        if (got !== exp) $display("FAIL rmid_after: got %h want %h", got, exp);
        else n_pass++;
        @(negedge clk); #1;
        got = {st(), gi, daddr}; exp = {4'b1110, 2'd0, 27'hA10};
        n_chk++;
        if (got !== exp) $display("FAIL rmid_regrant: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        int own, ptr, left, lastg, bc, c;
        logic ew, egv;
        logic [NR-1:0] ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0] eb, egi;
        logic [DW-1:0] d;
        do_reset();
        own = -1; ptr = 0; left = -1; lastg = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(99, 0) < 2);
            for (int i = 0; i < NR; i++) begin
                for (int k = 0; k < 8; k++) d[k*32+:32] = $urandom;
                set_req(i, ($urandom_range(99, 0) < 70), AW'($urandom),
                        2'($urandom_range(2, 0)), d);
            end
            dwait = ($urandom_range(99, 0) < 30);
            #1;
            egv = (own >= 0);
            ew  = egv && rwr[egv ? own : 0];
            ewr = '1;
            if (egv) ewr[own] = dwait;
            c   = egv ? own : 0;
            ea  = raddr[c*AW+:AW];
            ed  = rdata[c*DW+:DW];
            eb  = rbc[c*2+:2];
            egi = egv ? 2'(lastg) : 2'd0;
            got = {dwr, rwait, gv, (gv ? gi : 2'd0), daddr, dbc, ddata};
            exp = {ew, ewr, egv, egi, ea, eb, ed};
            n_chk++;
            if (got !== exp)
                $display("FAIL rand_cyc%0d: got %h want %h", cyc,
                         got[299:256], exp[299:256]);
            else n_pass++;
            if (rst) begin
                own = -1; ptr = 0; left = -1; lastg = 0;
            end else if (own < 0) begin
                for (int o = 0; o < NR; o++) begin
                    c = (ptr + o) % NR;
                    if (own < 0 && rwr[c]) begin
                        own = c; lastg = c; left = -1;
                    end
                end
            end else if (ew && !dwait) begin
                if (left < 0) begin
                    bc = int'(rbc[own*2+:2]);
                    if (bc == 0) bc = 1;
                    left = bc - 1;
                end else begin
                    left = left - 1;
                end
                if (left == 0) begin
                    ptr = (own + 1) % NR;
                    own = -1;
                end
            end else if (left < 0 && !rwr[own]) begin
                own = -1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle_all();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        idle_all();
        test_reset();
        test_single();
        test_simultaneous();
        test_stall();
        test_mixed();
        test_bc_zero();
        test_gap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
